// File: rtl/coef_ram_dp.sv
// True dual-port coefficient RAM for the NTT datapath: configurable geometry and read
// latency, cross-port read-during-write policy, write-collision flag and bulk-clear engine.
module coef_ram_dp #(
    parameter int unsigned WID        = 32,
    parameter int unsigned AWID       = 8,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned RDW_MODE   = 0,
    parameter int unsigned CLR_ON_RST = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr_req,
    output logic            clr_busy,
    input  logic            a_en,
    input  logic            a_we,
    input  logic [AWID-1:0] a_addr,
    input  logic [WID-1:0]  a_din,
    output logic [WID-1:0]  a_dout,
    output logic            a_vld,
    input  logic            b_en,
    input  logic            b_we,
    input  logic [AWID-1:0] b_addr,
    input  logic [WID-1:0]  b_din,
    output logic [WID-1:0]  b_dout,
    output logic            b_vld,
    output logic            wcoll
);

    localparam int unsigned DEP   = 1 << AWID;
    localparam int unsigned CNT_W = AWID - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEP / 2 - 1);

    if (!(RD_LAT == 1 || RD_LAT == 2)) begin : g_bad_rd_lat
        $fatal(1, "coef_ram_dp: RD_LAT must be 1 or 2");
    end
    if (AWID < 2) begin : g_bad_awid
        $fatal(1, "coef_ram_dp: AWID must be at least 2");
    end

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               clr_busy_q, clr_busy_d;
    logic               wcoll_q, wcoll_d;
    logic               a_s1_vld_q, a_s1_vld_d;
    logic [WID-1:0]     a_s1_data_q, a_s1_data_d;
    logic               b_s1_vld_q, b_s1_vld_d;
    logic [WID-1:0]     b_s1_data_q, b_s1_data_d;
    logic [WID-1:0]     mem_q [DEP];

    // Two internal write ports: A/B in IDLE, even/odd clear word pair in CLEAR
    logic               w0_en, w1_en;
    logic [AWID-1:0]    w0_addr, w1_addr;
    logic [WID-1:0]     w0_data, w1_data;
    logic               a_wr, a_rd, b_wr, b_rd, same_addr;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wcoll_d     = 1'b0;
        a_s1_vld_d  = 1'b0;
        a_s1_data_d = a_s1_data_q;
        b_s1_vld_d  = 1'b0;
        b_s1_data_d = b_s1_data_q;
        w0_en       = 1'b0;
        w0_addr     = a_addr;
        w0_data     = a_din;
        w1_en       = 1'b0;
        w1_addr     = b_addr;
        w1_data     = b_din;
        a_wr        = a_en && a_we;
        a_rd        = a_en && !a_we;
        b_wr        = b_en && b_we;
        b_rd        = b_en && !b_we;
        same_addr   = (a_addr == b_addr);

        case (state_q)
            ST_IDLE: begin
                // Port A wins a same-address write collision
                w0_en   = a_wr;
                w1_en   = b_wr && !(a_wr && same_addr);
                wcoll_d = a_wr && b_wr && same_addr;
                if (a_rd) begin
                    a_s1_vld_d  = 1'b1;
                    a_s1_data_d = (RDW_MODE != 0 && b_wr && same_addr) ? b_din : mem_q[a_addr];
                end
                if (b_rd) begin
                    b_s1_vld_d  = 1'b1;
                    b_s1_data_d = (RDW_MODE != 0 && a_wr && same_addr) ? a_din : mem_q[b_addr];
                end
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                w0_en   = 1'b1;
                w0_addr = {cnt_q, 1'b0};
                w0_data = '0;
                w1_en   = 1'b1;
                w1_addr = {cnt_q, 1'b1};
                w1_data = '0;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        clr_busy_d = (state_d == ST_CLEAR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= (CLR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
            cnt_q       <= '0;
            clr_busy_q  <= (CLR_ON_RST != 0);
            wcoll_q     <= 1'b0;
            a_s1_vld_q  <= 1'b0;
            a_s1_data_q <= '0;
            b_s1_vld_q  <= 1'b0;
            b_s1_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            clr_busy_q  <= clr_busy_d;
            wcoll_q     <= wcoll_d;
            a_s1_vld_q  <= a_s1_vld_d;
            a_s1_data_q <= a_s1_data_d;
            b_s1_vld_q  <= b_s1_vld_d;
            b_s1_data_q <= b_s1_data_d;
        end
    end

    // Array storage is deliberately not reset; only the clear engine zeroes it
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w0_en) mem_q[w0_addr] <= w0_data;
            if (w1_en) mem_q[w1_addr] <= w1_data;
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic           a_s2_vld_q, a_s2_vld_d;
        logic [WID-1:0] a_s2_data_q, a_s2_data_d;
        logic           b_s2_vld_q, b_s2_vld_d;
        logic [WID-1:0] b_s2_data_q, b_s2_data_d;

        always_comb begin
            a_s2_vld_d  = a_s1_vld_q;
            a_s2_data_d = a_s1_vld_q ? a_s1_data_q : a_s2_data_q;
            b_s2_vld_d  = b_s1_vld_q;
            b_s2_data_d = b_s1_vld_q ? b_s1_data_q : b_s2_data_q;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                a_s2_vld_q  <= 1'b0;
                a_s2_data_q <= '0;
                b_s2_vld_q  <= 1'b0;
                b_s2_data_q <= '0;
            end else begin
                a_s2_vld_q  <= a_s2_vld_d;
                a_s2_data_q <= a_s2_data_d;
                b_s2_vld_q  <= b_s2_vld_d;
                b_s2_data_q <= b_s2_data_d;
            end
        end

        assign a_vld  = a_s2_vld_q;
        assign a_dout = a_s2_data_q;
        assign b_vld  = b_s2_vld_q;
        assign b_dout = b_s2_data_q;
    end else begin : g_lat1
        assign a_vld  = a_s1_vld_q;
        assign a_dout = a_s1_data_q;
        assign b_vld  = b_s1_vld_q;
        assign b_dout = b_s1_data_q;
    end

    assign clr_busy = clr_busy_q;
    assign wcoll    = wcoll_q;

endmodule

// File: doc/coef_ram_dp.md
Name: coef_ram_dp

Overview:
- Parametrised true dual-port coefficient RAM for the NTT datapath; successor to the fixed 32x256 two-port store.
- Adds configurable width/depth, selectable read latency, defined read-during-write and write-collision rules, and per-port read-valid strobes.
- Adds a hardware bulk-clear engine that zeroes the array on reset or on request.
- Sits between the butterfly units and the coefficient load/unload controller.

Parameters:
- WID, 32, data word width in bits.
- AWID, 8, address width; depth DEP = 2**AWID, which must be even.
- RD_LAT, 1, read latency in cycles; legal values are 1 or 2.
- RDW_MODE, 0, cross-port read-during-write to the same address. 0 = read returns old data; 1 = read returns the new write data.
- CLR_ON_RST, 1, when 1 a reset starts a bulk clear.

Ports:
- clk  in  1  clock. One clock domain, all logic on the rising edge.
- rst  in  1  reset. Synchronous, active-high.
- clr_req  in  1  single-cycle request to start a bulk clear.
- clr_busy  out  1  high while the clear engine owns the array.
- a_en  in  1  port A access enable.
- a_we  in  1  port A write enable; qualified by a_en.
- a_addr  in  AWID  port A address.
- a_din  in  WID  port A write data.
- a_dout  out  WID  port A read data.
- a_vld  out  1  port A read-data valid strobe.
- b_en, b_we, b_addr, b_din, b_dout, b_vld: same as port A, for port B.
- wcoll  out  1  pulses when both ports write the same address in the same cycle.

Behaviour:
- Reset values: a_dout=0, b_dout=0, a_vld=0, b_vld=0, wcoll=0, all read pipeline stages cleared.
- On reset the FSM enters CLEAR if CLR_ON_RST=1, otherwise IDLE. clr_busy=1 in the cycle after rst when CLR_ON_RST=1.
- Array contents are not reset except through CLEAR.
- FSM states:
  - IDLE: port accesses serviced. clr_req=1 -> CLEAR, counter cleared to 0.
  - CLEAR: each cycle writes 0 to addresses 2*cnt and 2*cnt+1; cnt increments.
  - CLEAR exit: when cnt reaches DEP/2-1, that cycle is the last write and the FSM returns to IDLE. CLEAR therefore lasts exactly DEP/2 cycles.
- During CLEAR:
  - Port enables are ignored; no writes land, a_vld/b_vld stay 0, a_dout/b_dout hold.
  - clr_req is ignored.
  - rst restarts the clear at cnt=0 (or goes to IDLE if CLR_ON_RST=0).
- Port read: a_en=1, a_we=0 in IDLE in cycle t.
  - a_dout is updated and a_vld=1 at edge t+RD_LAT.
  - Otherwise a_vld=0 and a_dout holds its last value.
  - Back-to-back reads are fully pipelined at one per cycle.
- Port write: a_en=1, a_we=1.
  - mem[a_addr] is updated at the edge; no read occurs and a_vld=0 for that slot.
- Same-port write followed by a read of the same address in the next cycle returns the new data.
- Cross-port read-during-write (A reads address X while B writes X):
  - RDW_MODE=0: A returns the pre-write value.
  - RDW_MODE=1: A returns b_din.
  - The same rule applies symmetrically with the ports swapped.
- Write collision (both ports write address X in the same cycle):
  - Port A data is stored; port B write is dropped.
  - wcoll=1 for exactly one cycle, registered, asserted at the edge after the collision.
- Both ports reading the same address is legal; both return the same data.
- RD_LAT=2 adds one output register stage. Reset clears the valid bits in flight.
- A pending read in the pipeline when CLEAR starts still completes, returning pre-clear data.
- An illegal RD_LAT value is a simulation-time fatal error.

Test Plan:
- DEP=256, CLR_ON_RST=1: pulse rst -> clr_busy high exactly 128 cycles. After that, reading any of 0,1,127,254,255 returns 0.
- Write 0xDEADBEEF to A addr 5, then read on B addr 5:
  - RD_LAT=1: b_vld=1 and b_dout=0xDEADBEEF one cycle after the read.
  - RD_LAT=2: same data, two cycles after the read.
- Preload addr 9 with 0x11. A writes 0x22 to addr 9 while B reads addr 9 in the same cycle:
  - RDW_MODE=0: b_dout=0x11.
  - RDW_MODE=1: b_dout=0x22.
- A writes 0xAAAA and B writes 0xBBBB to addr 3 in the same cycle -> wcoll pulses one cycle; a later read of addr 3 returns 0xAAAA.
- clr_req while 4 reads are streaming:
  - In-flight reads complete with old data.
  - Port requests made during clr_busy produce no vld.
  - After clear, addr 0 reads back 0.
- rst asserted at cycle 40 of a clear -> clr_busy stays high and the clear restarts at cnt=0, finishing 128 cycles after rst.
